mult_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one sequential `mult` instance between `N_REQ` requesters in the `cordic_sqrt_seq` datapath. Each requester presents operands and signedness flags under a level request. The block grants one requester at a time, drives the `mult` start/clear controls, and captures `prod` on `prod_valid`. It returns the product to the granted requester with a one-cycle response strobe.

---
 rtl/mult_arb_pkg.sv | 32 +++
 rtl/mult_arb_if.sv | 29 ++
 rtl/mult_arb_mult.sv | 79 +++++++
 rtl/mult_arb.sv | 150 +++++++++++++++
 tb/tb_mult_arb.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/mult_arb_pkg.sv
// Shared types and the round-robin grant helper for the mult arbiter.
package mult_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam int unsigned MAX_REQ = 8;

  // First requester after 'last' (wrapping at n_req-1) with req set; keeps 'last' if none.
  function automatic logic [2:0] rr_next(input logic [MAX_REQ-1:0] req,
                                         input logic [2:0]         last,
                                         input int unsigned        n_req);
    logic [2:0]  pick;
    logic        found;
    logic        hit;
    int unsigned idx;
    pick  = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_REQ; i++) begin
      idx   = (32'(last) + i) % n_req;
      hit   = !found && (i <= n_req) && req[idx[2:0]];
      pick  = hit ? idx[2:0] : pick;
      found = found | hit;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mult_arb_if.sv
// Requester-side bundle of the mult arbiter: requests, operands, grants and responses.
interface mult_arb_if #(
  parameter int N_REQ    = 2,
  parameter int BW_MCAND = 3,
  parameter int BW_MLIER = 4
);
  localparam int BW_PROD = BW_MCAND + BW_MLIER;

  logic [N_REQ-1:0]          req;
  logic [N_REQ*BW_MCAND-1:0] req_mcand;
  logic [N_REQ*BW_MLIER-1:0] req_mlier;
  logic [N_REQ-1:0]          req_mcand_is_signed;
  logic [N_REQ-1:0]          req_mlier_is_signed;
  logic [N_REQ-1:0]          gnt;
  logic [N_REQ-1:0]          rsp_valid;
  logic [BW_PROD-1:0]        rsp_prod;
  logic                      busy;

  modport master (
    output req, req_mcand, req_mlier, req_mcand_is_signed, req_mlier_is_signed,
    input  gnt, rsp_valid, rsp_prod, busy
  );

  modport slave (
    input  req, req_mcand, req_mlier, req_mcand_is_signed, req_mlier_is_signed,
    output gnt, rsp_valid, rsp_prod, busy
  );

endinterface

// File: rtl/mult_arb_mult.sv
// Sequential shift-add multiplier; operands are extended to the product width so the
// low BW_PROD bits of the sum are correct for every signedness combination.
module mult #(
  parameter int BW_CNT   = 3,
  parameter int BW_MCAND = 3,
  parameter int BW_MLIER = 4
) (
  input  logic                         clk,
  input  logic                         rstx,
  input  logic                         start,
  input  logic                         clear,
  input  logic [BW_MCAND-1:0]          mcand,
  input  logic [BW_MLIER-1:0]          mlier,
  input  logic                         mcand_is_signed,
  input  logic                         mlier_is_signed,
  output logic [BW_MCAND+BW_MLIER-1:0] prod,
  output logic                         prod_valid
);
  localparam int BW_PROD = BW_MCAND + BW_MLIER;

  logic [BW_PROD-1:0] acc_q, acc_d, a_q, a_d, b_q, b_d, sum_s;
  logic [BW_CNT-1:0]  cnt_q, cnt_d;
  logic               run_q, run_d, valid_q, valid_d;

  // One partial product per cycle; prod_valid stays high until the next start or clear.
  always_comb begin
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    valid_d = valid_q;
    sum_s   = acc_q + (b_q[0] ? a_q : {BW_PROD{1'b0}});
    if (clear) begin
      acc_d   = '0;
      cnt_d   = '0;
      run_d   = 1'b0;
      valid_d = 1'b0;
    end else if (start) begin
      acc_d   = '0;
      a_d     = {{(BW_PROD-BW_MCAND){mcand_is_signed & mcand[BW_MCAND-1]}}, mcand};
      b_d     = {{(BW_PROD-BW_MLIER){mlier_is_signed & mlier[BW_MLIER-1]}}, mlier};
      cnt_d   = BW_CNT'(BW_PROD - 1);
      run_d   = 1'b1;
      valid_d = 1'b0;
    end else if (run_q) begin
      acc_d   = sum_s;
      a_d     = a_q << 1;
      b_d     = b_q >> 1;
      cnt_d   = cnt_q - BW_CNT'(1);
      run_d   = (cnt_q != '0);
      valid_d = (cnt_q == '0);
    end else begin
      run_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstx) begin
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      valid_q <= valid_d;
    end
  end

  assign prod       = acc_q;
  assign prod_valid = valid_q;

endmodule

// File: rtl/mult_arb.sv
// Round-robin arbiter sharing one sequential mult between N_REQ requesters.
module mult_arb
  import mult_arb_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int BW_CNT   = 3,
  parameter int BW_MCAND = 3,
  parameter int BW_MLIER = 4
) (
  input  logic       clk,
  input  logic       rstx,
  input  logic       clear,
  mult_arb_if.slave  bus
);
  localparam int BW_PROD = BW_MCAND + BW_MLIER;

  arb_state_e          state_q, state_d;
  logic [2:0]          gnt_idx_q, gnt_idx_d, last_q, last_d, pick_s;
  logic [BW_MCAND-1:0] mcand_q, mcand_d, mcand_sel_s;
  logic [BW_MLIER-1:0] mlier_q, mlier_d, mlier_sel_s;
  logic                mcand_sgn_q, mcand_sgn_d, mlier_sgn_q, mlier_sgn_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d, rsp_valid_q, rsp_valid_d, onehot_s;
  logic                busy_q, busy_d, rst_dly_q;
  logic [BW_PROD-1:0]  rsp_prod_q, rsp_prod_d, prod_s;
  logic [MAX_REQ-1:0]  req_pad_s;
  logic                prod_valid_s, mult_start_s, mult_clear_s;

  // Arbitration, operand latch, FSM next state and registered-output next values.
  always_comb begin
    req_pad_s              = '0;
    req_pad_s[N_REQ-1:0]   = bus.req;
    pick_s                 = rr_next(req_pad_s, last_q, N_REQ);
    mcand_sel_s            = '0;
    mlier_sel_s            = '0;
    for (int i = 0; i < N_REQ; i++) begin
      mcand_sel_s = (pick_s == 3'(i)) ? bus.req_mcand[i*BW_MCAND +: BW_MCAND] : mcand_sel_s;
      mlier_sel_s = (pick_s == 3'(i)) ? bus.req_mlier[i*BW_MLIER +: BW_MLIER] : mlier_sel_s;
    end
    state_d     = state_q;
    gnt_idx_d   = gnt_idx_q;
    last_d      = last_q;
    mcand_d     = mcand_q;
    mlier_d     = mlier_q;
    mcand_sgn_d = mcand_sgn_q;
    mlier_sgn_d = mlier_sgn_q;
    rsp_prod_d  = rsp_prod_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d     = START;
          gnt_idx_d   = pick_s;
          mcand_d     = mcand_sel_s;
          mlier_d     = mlier_sel_s;
          mcand_sgn_d = bus.req_mcand_is_signed[pick_s];
          mlier_sgn_d = bus.req_mlier_is_signed[pick_s];
        end else begin
          state_d = IDLE;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (prod_valid_s) begin
          state_d    = DONE;
          rsp_prod_d = prod_s;
        end else begin
          state_d = WAIT;
        end
      end
      DONE: begin
        state_d = IDLE;
        last_d  = gnt_idx_q;
      end
      default: state_d = IDLE;
    endcase
    // A flush abandons the operation without touching the round-robin pointer.
    if (clear) begin
      state_d     = IDLE;
      gnt_idx_d   = gnt_idx_q;
      last_d      = last_q;
      mcand_d     = mcand_q;
      mlier_d     = mlier_q;
      mcand_sgn_d = mcand_sgn_q;
      mlier_sgn_d = mlier_sgn_q;
      rsp_prod_d  = '0;
    end else begin
      rsp_prod_d  = rsp_prod_d;
    end
    onehot_s    = {{(N_REQ-1){1'b0}}, 1'b1} << gnt_idx_d;
    gnt_d       = (state_d != IDLE) ? onehot_s : '0;
    rsp_valid_d = (state_d == DONE) ? onehot_s : '0;
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstx) begin
      state_q     <= IDLE;
      gnt_idx_q   <= '0;
      last_q      <= 3'(N_REQ - 1);
      mcand_q     <= '0;
      mlier_q     <= '0;
      mcand_sgn_q <= 1'b0;
      mlier_sgn_q <= 1'b0;
      rsp_prod_q  <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
      rst_dly_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      gnt_idx_q   <= gnt_idx_d;
      last_q      <= last_d;
      mcand_q     <= mcand_d;
      mlier_q     <= mlier_d;
      mcand_sgn_q <= mcand_sgn_d;
      mlier_sgn_q <= mlier_sgn_d;
      rsp_prod_q  <= rsp_prod_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      rst_dly_q   <= 1'b0;
    end
  end

  // The mult is also held in clear for the first cycle out of reset.
  assign mult_start_s = (state_q == START);
  assign mult_clear_s = ~rstx | clear | rst_dly_q;

  mult #(
    .BW_CNT   (BW_CNT),
    .BW_MCAND (BW_MCAND),
    .BW_MLIER (BW_MLIER)
  ) u_mult (
    .clk             (clk),
    .rstx            (rstx),
    .start           (mult_start_s),
    .clear           (mult_clear_s),
    .mcand           (mcand_q),
    .mlier           (mlier_q),
    .mcand_is_signed (mcand_sgn_q),
    .mlier_is_signed (mlier_sgn_q),
    .prod            (prod_s),
    .prod_valid      (prod_valid_s)
  );

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rsp_valid_q & {N_REQ{rstx & ~clear}};
  assign bus.rsp_prod  = rsp_prod_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mult_arb.sv
// Directed bench for mult_arb: reset, single ops, round-robin, clear, reset mid-op, full sweep.
module tb_mult_arb;

  logic clk;
  logic rstx;
  logic clear;
  int   n_chk;
  int   n_err;
  logic seen;

  mult_arb_if #(.N_REQ(2), .BW_MCAND(3), .BW_MLIER(4)) bif ();

  mult_arb #(.N_REQ(2), .BW_CNT(3), .BW_MCAND(3), .BW_MLIER(4)) dut (
    .clk   (clk),
    .rstx  (rstx),
    .clear (clear),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ref_prod(input logic [2:0] mc, input logic [3:0] ml,
                                          input logic sc, input logic sl);
    int a;
    int b;
    int p;
    a = sc ? int'($signed(mc)) : int'(mc);
    b = sl ? int'($signed(ml)) : int'(ml);
    p = a * b;
    return p[6:0];
  endfunction

  function automatic logic [1:0] oh(input int r);
    logic [1:0] one;
    one = 2'b01;
    return one << r;
  endfunction

  task automatic set_ops(input int r, input logic [2:0] mc, input logic [3:0] ml,
                         input logic sc, input logic sl);
    bif.req_mcand[r*3 +: 3]       = mc;
    bif.req_mlier[r*4 +: 4]       = ml;
    bif.req_mcand_is_signed[r]    = sc;
    bif.req_mlier_is_signed[r]    = sl;
  endtask

  // Issue one request from requester r and follow it to its response; called at a negedge.
  task automatic run_op(input int r, input logic [2:0] mc, input logic [3:0] ml,
                        input logic sc, input logic sl, input logic [6:0] exp_p, input string tag);
    int cnt;
    set_ops(r, mc, ml, sc, sl);
    bif.req[r] = 1'b1;
    @(negedge clk);
    check({tag, "_gnt"}, 32'(bif.gnt), 32'(oh(r)));
    cnt = 0;
    while (bif.rsp_valid == 2'b00 && cnt < 30) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, "_rsp_valid"}, 32'(bif.rsp_valid), 32'(oh(r)));
    check({tag, "_prod"}, 32'(bif.rsp_prod), 32'(exp_p));
    bif.req[r] = 1'b0;
    @(negedge clk);
    check({tag, "_idle"}, {30'd0, bif.busy, |bif.rsp_valid}, 32'd0);
  endtask

  task automatic wait_rsp(output int cnt);
    cnt = 0;
    while (bif.rsp_valid == 2'b00 && cnt < 30) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  initial begin
    int cnt;
    int r;
    n_chk = 0;
    n_err = 0;
    rstx  = 1'b0;
    clear = 1'b0;
    bif.req = 2'b00;
    bif.req_mcand = 6'd0;
    bif.req_mlier = 8'd0;
    bif.req_mcand_is_signed = 2'b00;
    bif.req_mlier_is_signed = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(bif.gnt), 32'd0);
    check("rst_rsp_valid", 32'(bif.rsp_valid), 32'd0);
    check("rst_busy", 32'(bif.busy), 32'd0);
    check("rst_prod", 32'(bif.rsp_prod), 32'd0);
    rstx = 1'b1;
    @(negedge clk);

    // Both requesters held: 0 first after reset, then alternating with an IDLE gap.
    set_ops(0, 3'd2, 4'd3, 1'b0, 1'b0);
    set_ops(1, 3'd3, 4'd4, 1'b0, 1'b0);
    bif.req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rr_gnt", 32'(bif.gnt), 32'(oh(k % 2)));
      check("rr_busy", 32'(bif.busy), 32'd1);
      wait_rsp(cnt);
      check("rr_rsp_valid", 32'(bif.rsp_valid), 32'(oh(k % 2)));
      check("rr_prod", 32'(bif.rsp_prod), (k % 2 == 0) ? 32'd6 : 32'd12);
      @(negedge clk);
      check("rr_idle_gap", {30'd0, bif.busy, |bif.gnt}, 32'd0);
    end
    bif.req = 2'b00;
    @(negedge clk);

    run_op(0, 3'd3, 4'd5, 1'b0, 1'b0, 7'd15, "u3x5");
    run_op(1, 3'b101, 4'b1110, 1'b1, 1'b1, 7'd6, "s_m3xm2");
    run_op(0, 3'b101, 4'b1111, 1'b1, 1'b0, 7'b1010011, "m3x15");

    // Clear during WAIT of requester 0 discards the result.
    set_ops(0, 3'd2, 4'd5, 1'b0, 1'b0);
    bif.req[0] = 1'b1;
    repeat (3) @(negedge clk);
    clear = 1'b1;
    bif.req[0] = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    check("clr_state", {29'd0, bif.busy, bif.gnt}, 32'd0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | (|bif.rsp_valid);
    end
    check("clr_no_rsp", 32'(seen), 32'd0);
    run_op(0, 3'd2, 4'd5, 1'b0, 1'b0, 7'd10, "clr_retry");

    // Reset for one cycle in WAIT: outputs drop and no stale response appears.
    set_ops(0, 3'd3, 4'd3, 1'b0, 1'b0);
    bif.req[0] = 1'b1;
    repeat (3) @(negedge clk);
    rstx = 1'b0;
    bif.req[0] = 1'b0;
    @(negedge clk);
    rstx = 1'b1;
    check("rstw_state", {29'd0, bif.busy, bif.gnt}, 32'd0);
    check("rstw_prod", 32'(bif.rsp_prod), 32'd0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | (|bif.rsp_valid);
    end
    check("rstw_no_rsp", 32'(seen), 32'd0);
    run_op(0, 3'd3, 4'd3, 1'b0, 1'b0, 7'd9, "rstw_retry");

    // Every operand pair in every signedness mode, alternating requesters.
    for (int mode = 0; mode < 4; mode++) begin
      for (int mc = 0; mc < 8; mc++) begin
        for (int ml = 0; ml < 16; ml++) begin
          r = (mc + ml) % 2;
          run_op(r, 3'(mc), 4'(ml), mode[1], mode[0],
                 ref_prod(3'(mc), 4'(ml), mode[1], mode[0]), "sweep");
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
